// File: rtl/ms_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ms_ctrl_pkg : shared state encoding and sizing helper for ms_counter_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ms_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_SAT   = 2'b11
  } state_t;

  function automatic int div_w(input int clk_hz, input int tick_hz);
    int div;
    div = clk_hz / tick_hz;
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler : divide-by-DIV counter, one-cycle wrap pulse while running
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tick_prescaler
  import ms_ctrl_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic CLK,
  input  logic RST,
  input  logic run,
  input  logic load0,
  output logic tick
);

  localparam int W = div_w(DIV, 1);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = run && !load0 && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (load0) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ms_counter_ctrl.sv
// ---------------------------------------------------------------------------
// ms_counter_ctrl : run/pause/clear control and 1 ms tick for the ms counter
// Optional lap display hold: define LAP_HOLD_EN.                    Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ms_counter_ctrl
  import ms_ctrl_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START_STOP,
  input  logic       CLR,
  input  logic       LAP,
  input  logic       MAX_IN,
  output logic       CNT_EN,
  output logic       CNT_CLR,
  output logic       TICK_MS,
  output logic       DISP_HOLD,
  output logic [1:0] STATE
);

  localparam int DIV = CLK_HZ / TICK_HZ;

  generate
    if ((DIV < 2) || (DIV * TICK_HZ != CLK_HZ)) begin : g_bad_div
      $error("ms_counter_ctrl: CLK_HZ/TICK_HZ must be an integer >= 2");
    end
  endgenerate

  state_t state_q, state_d;
  logic   cnt_en_q, cnt_en_d;
  logic   cnt_clr_q, cnt_clr_d;
  logic   tick_q, tick_d;
  logic   hold_q, hold_d;
  logic   run, load0, tick;

  // CLR stops the prescaler in the same cycle so a coincident wrap is lost.
  assign run   = (state_q == ST_RUN) && !CLR;
  assign load0 = CLR || ((state_q == ST_IDLE) && START_STOP);

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .CLK   (CLK),
    .RST   (RST),
    .run   (run),
    .load0 (load0),
    .tick  (tick)
  );

`ifndef LAP_HOLD_EN
  logic unused_lap;
  assign unused_lap = LAP;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_en_d  = 1'b0;
    cnt_clr_d = 1'b0;
    tick_d    = 1'b0;
    hold_d    = hold_q;
    if (CLR) begin
      state_d   = ST_IDLE;
      cnt_clr_d = 1'b1;
      hold_d    = 1'b0;
    end else begin
      tick_d   = tick;
      cnt_en_d = tick && !MAX_IN;
      case (state_q)
        ST_IDLE:  if (START_STOP) state_d = ST_RUN;
        ST_RUN: begin
          if (tick && MAX_IN)  state_d = ST_SAT;
          else if (START_STOP) state_d = ST_PAUSE;
        end
        ST_PAUSE: if (START_STOP) state_d = ST_RUN;
        default:  state_d = ST_SAT;
      endcase
`ifdef LAP_HOLD_EN
      // SAT ignores START_STOP, so it does not mask LAP there.
      if (LAP && (state_q == ST_SAT || (state_q == ST_RUN && !START_STOP))) begin
        hold_d = !hold_q;
      end
`else
      hold_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      tick_q    <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= cnt_clr_d;
      tick_q    <= tick_d;
      hold_q    <= hold_d;
    end
  end

  assign CNT_EN    = cnt_en_q;
  assign CNT_CLR   = cnt_clr_q;
  assign TICK_MS   = tick_q;
  assign DISP_HOLD = hold_q;
  assign STATE     = state_q;

endmodule

`default_nettype wire
